// File: rtl/inport_debounce_if.sv
// inport_debounce_if: groups the raw board inputs, the processor acknowledge
// and the captured-data outputs of the input-port debouncer.
// master: board/processor side; slave: the debouncer itself.
interface inport_debounce_if #(
  parameter int SW_WIDTH = 8
);
  logic [SW_WIDTH-1:0] Switches;
  logic                Button;
  logic                Read_Ack;
  logic [31:0]         INPort_Data;
  logic                Press_Pulse;
  logic                Data_Valid;
  logic                Overrun;

  modport master (
    output Switches,
    output Button,
    output Read_Ack,
    input  INPort_Data,
    input  Press_Pulse,
    input  Data_Valid,
    input  Overrun
  );

  modport slave (
    input  Switches,
    input  Button,
    input  Read_Ack,
    output INPort_Data,
    output Press_Pulse,
    output Data_Valid,
    output Overrun
  );
endinterface

// File: rtl/inport_debounce.sv
// inport_debounce: debounces a push button and, on each accepted press,
// captures the switch word into a 32-bit input-port register with a
// valid/overrun handshake towards the processor.
// Optional macro INPORT_SYNC_EN: adds a two-flop synchronizer on Button and
// Switches (press latency becomes DEBOUNCE_CYCLES+2 instead of DEBOUNCE_CYCLES).
module inport_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SW_WIDTH        = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  inport_debounce_if.slave bus
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t              state_r;
  logic [CW-1:0]       cnt_r;
  logic                btn_s;
  logic [SW_WIDTH-1:0] sw_s;
  logic                capture_s;
  logic [31:0]         cap_word_s;
  logic [31:0]         data_r;
  logic                press_pulse_r;
  logic                data_valid_r;
  logic                overrun_r;

`ifdef INPORT_SYNC_EN
  logic                btn_meta_r;
  logic                btn_sync_r;
  logic [SW_WIDTH-1:0] sw_meta_r;
  logic [SW_WIDTH-1:0] sw_sync_r;

  // Two-flop synchronizers bringing the asynchronous board inputs into Clock.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      btn_meta_r <= 1'b0;
      btn_sync_r <= 1'b0;
      sw_meta_r  <= '0;
      sw_sync_r  <= '0;
    end else begin
      btn_meta_r <= bus.Button;
      btn_sync_r <= btn_meta_r;
      sw_meta_r  <= bus.Switches;
      sw_sync_r  <= sw_meta_r;
    end
  end

  assign btn_s = btn_sync_r;
  assign sw_s  = sw_sync_r;
`else
  assign btn_s = bus.Button;
  assign sw_s  = bus.Switches;
`endif

  // A capture happens on the edge that qualifies a press (PRESS_WAIT -> HELD).
  always_comb begin
    capture_s  = (state_r == PRESS_WAIT) && btn_s && (cnt_r == CNT_MAX);
    cap_word_s = 32'd0;
    cap_word_s[SW_WIDTH-1:0] = sw_s;
  end

  // Debounce FSM; the counter is reloaded on every state entry so it never wraps.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      press_pulse_r <= 1'b0;
    end else begin
      press_pulse_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (btn_s) begin
            state_r <= PRESS_WAIT;
            cnt_r   <= '0;
          end else begin
            state_r <= IDLE;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end else if (cnt_r == CNT_MAX) begin
            state_r       <= HELD;
            cnt_r         <= '0;
            press_pulse_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state_r <= RELEASE_WAIT;
            cnt_r   <= '0;
          end else begin
            state_r <= HELD;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state_r <= HELD;
            cnt_r   <= '0;
          end else if (cnt_r == CNT_MAX) begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Captured word plus valid/overrun handshake; a capture wins over Read_Ack.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      data_r       <= 32'd0;
      data_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else if (capture_s) begin
      data_r       <= cap_word_s;
      data_valid_r <= 1'b1;
      if (bus.Read_Ack) begin
        overrun_r <= 1'b0;
      end else if (data_valid_r) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end else if (bus.Read_Ack) begin
      data_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      data_valid_r <= data_valid_r;
      overrun_r    <= overrun_r;
    end
  end

  assign bus.INPort_Data = data_r;
  assign bus.Press_Pulse = press_pulse_r;
  assign bus.Data_Valid  = data_valid_r;
  assign bus.Overrun     = overrun_r;

endmodule

// File: tb/tb_inport_debounce.sv
// tb_inport_debounce: directed test of inport_debounce with DEBOUNCE_CYCLES=4.
// Press latency is 4 edges, or 6 when INPORT_SYNC_EN is defined.
module tb_inport_debounce;

  localparam int DEB = 4;
`ifdef INPORT_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int LAT = DEB + SYNC;

  logic Clock;
  logic Reset;
  int   errors;
  int   checks;
  int   pulses;

  inport_debounce_if #(.SW_WIDTH(8)) bus ();

  inport_debounce #(.DEBOUNCE_CYCLES(DEB), .SW_WIDTH(8)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full clean press and release; counts pulses seen along the way.
  task automatic press(input logic [7:0] sw, output int npulse);
    npulse = 0;
    bus.Switches = sw;
    bus.Button   = 1'b1;
    for (int i = 0; i < LAT + 1; i++) begin
      step();
      if (bus.Press_Pulse === 1'b1) npulse++;
    end
    bus.Button = 1'b0;
    for (int i = 0; i < LAT + 6; i++) begin
      step();
      if (bus.Press_Pulse === 1'b1) npulse++;
    end
  endtask

  task automatic ack();
    bus.Read_Ack = 1'b1;
    step();
    bus.Read_Ack = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    Reset        = 1'b0;
    bus.Switches = 8'h00;
    bus.Button   = 1'b0;
    bus.Read_Ack = 1'b0;
    step();
    step();
    check("rst_data",    bus.INPort_Data, 32'h0000_0000);
    check("rst_pulse",   {31'd0, bus.Press_Pulse}, 32'd0);
    check("rst_valid",   {31'd0, bus.Data_Valid},  32'd0);
    check("rst_overrun", {31'd0, bus.Overrun},     32'd0);
    Reset = 1'b1;
    step();
    step();

    // Single clean press: pulse only after edge LAT.
    bus.Switches = 8'hC0;
    bus.Button   = 1'b1;
    for (int i = 0; i <= LAT + 2; i++) begin
      step();
      check($sformatf("c0_pulse_e%0d", i), {31'd0, bus.Press_Pulse}, {31'd0, (i == LAT)});
    end
    check("c0_data",    bus.INPort_Data, 32'h0000_00C0);
    check("c0_valid",   {31'd0, bus.Data_Valid}, 32'd1);
    check("c0_overrun", {31'd0, bus.Overrun},    32'd0);
    bus.Button = 1'b0;
    for (int i = 0; i < LAT + 6; i++) step();
    ack();
    check("c0_ack_valid", {31'd0, bus.Data_Valid}, 32'd0);
    check("c0_ack_data",  bus.INPort_Data, 32'h0000_00C0);

    // Bouncing button (high 2 / low 1) never qualifies; switches ignored.
    pulses = 0;
    bus.Switches = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      bus.Button = (i % 3 != 2);
      step();
      if (bus.Press_Pulse === 1'b1) pulses++;
    end
    bus.Button = 1'b0;
    for (int i = 0; i < LAT + 6; i++) begin
      step();
      if (bus.Press_Pulse === 1'b1) pulses++;
    end
    check("bounce_pulses", pulses, 32'd0);
    check("bounce_data",   bus.INPort_Data, 32'h0000_00C0);
    check("bounce_valid",  {31'd0, bus.Data_Valid}, 32'd0);

    // Two presses without acknowledge -> overrun, newest data kept.
    press(8'h12, pulses);
    check("p12_pulses",  pulses, 32'd1);
    check("p12_data",    bus.INPort_Data, 32'h0000_0012);
    check("p12_overrun", {31'd0, bus.Overrun}, 32'd0);
    press(8'h34, pulses);
    check("p34_pulses",  pulses, 32'd1);
    check("p34_data",    bus.INPort_Data, 32'h0000_0034);
    check("p34_valid",   {31'd0, bus.Data_Valid}, 32'd1);
    check("p34_overrun", {31'd0, bus.Overrun},    32'd1);
    ack();
    check("ov_ack_valid",   {31'd0, bus.Data_Valid}, 32'd0);
    check("ov_ack_overrun", {31'd0, bus.Overrun},    32'd0);
    check("ov_ack_data",    bus.INPort_Data, 32'h0000_0034);

    // Read_Ack coinciding with the second capture: valid stays, no overrun.
    press(8'h56, pulses);
    check("p56_valid", {31'd0, bus.Data_Valid}, 32'd1);
    bus.Switches = 8'h78;
    bus.Button   = 1'b1;
    for (int i = 0; i < LAT; i++) step();
    bus.Read_Ack = 1'b1;
    step();
    bus.Read_Ack = 1'b0;
    check("coin_pulse",   {31'd0, bus.Press_Pulse}, 32'd1);
    check("coin_valid",   {31'd0, bus.Data_Valid},  32'd1);
    check("coin_overrun", {31'd0, bus.Overrun},     32'd0);
    check("coin_data",    bus.INPort_Data, 32'h0000_0078);
    bus.Button = 1'b0;
    for (int i = 0; i < LAT + 6; i++) step();
    ack();
    check("coin_ack_valid", {31'd0, bus.Data_Valid}, 32'd0);

    // Reset two cycles into PRESS_WAIT abandons the press; full requalification after.
    bus.Switches = 8'h9A;
    bus.Button   = 1'b1;
    for (int i = 0; i < SYNC + 2; i++) step();
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("rst_mid_pulse%0d", i), {31'd0, bus.Press_Pulse}, 32'd0);
    end
    check("rst_mid_data",  bus.INPort_Data, 32'h0000_0000);
    check("rst_mid_valid", {31'd0, bus.Data_Valid}, 32'd0);
    Reset = 1'b1;
    for (int i = 0; i <= LAT + 1; i++) begin
      step();
      check($sformatf("rst_rel_pulse_e%0d", i), {31'd0, bus.Press_Pulse}, {31'd0, (i == LAT)});
    end
    check("rst_rel_data", bus.INPort_Data, 32'h0000_009A);
    bus.Button = 1'b0;
    for (int i = 0; i < LAT + 6; i++) step();
    ack();

    // Long hold with a 2-cycle low glitch: exactly one pulse.
    pulses = 0;
    bus.Switches = 8'h5A;
    for (int i = 0; i < 100; i++) begin
      bus.Button = !(i == 50 || i == 51);
      step();
      if (bus.Press_Pulse === 1'b1) pulses++;
    end
    bus.Button = 1'b0;
    for (int i = 0; i < LAT + 6; i++) begin
      step();
      if (bus.Press_Pulse === 1'b1) pulses++;
    end
    check("hold_pulses", pulses, 32'd1);
    check("hold_data",   bus.INPort_Data, 32'h0000_005A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
